alpha_trim_mean: RTL and testbench
==================================

// Module: alpha_trim_mean
// PURPOSE
//  Stage directly after parallel_sort in the modified alpha-trimmed mean filter. On sort_finish it latches the
//  5x5 window and the rank->index list. It accumulates the DN-2*TRIM middle-ranked pixels, one per clock.
//  It then divides the sum by the kept count with round-half-up and outputs one filtered pixel with a 1-cycle valid.
// PARAMETERS
//  DN    25                        pixels per window
//  DW    8                         pixel width
//  TRIM  4                         pixels discarded at each end (lowest TRIM, highest TRIM); 2*TRIM<DN, else elaboration error
//  SW    $clog2(DN)                rank/index field width
//  NK    DN-2*TRIM                 kept pixel count (derived, do not override)
//  SUMW  DW+$clog2(NK)+1           accumulator/divider width
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous, active-high reset
//  sort_finish      in   1       start pulse from parallel_sort; sampled only in IDLE
//  data_unsort      in   DW*DN   window pixels; pixel i at [i*DW+:DW]; valid in the sort_finish cycle
//  sequence_sorted  in   SW*DN   field r = original index of the r-th smallest pixel; valid in the sort_finish cycle
//  busy             out  1       high from the cycle after an accepted start until mean_valid, inclusive
//  mean_out         out  DW      trimmed mean; holds until the next result or reset
//  mean_valid       out  1       1-cycle pulse when mean_out updates
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, mean_out=0, mean_valid=0; window/seq latches, acc, rank counter, divider regs all 0.
//  FSM (one-hot): IDLE -> ACC -> DIV -> DONE -> IDLE.
//   IDLE: when sort_finish=1, latch data_unsort and sequence_sorted, set acc=0, set rank=TRIM, go to ACC.
//   ACC: acc += win[seq[rank]]; rank++. Exactly NK cycles. After the rank=DN-1-TRIM add, load the dividend
//     acc_final+(NK>>1) and the divisor NK, then go to DIV.
//   DIV: restoring division, 1 quotient bit per cycle, MSB first, exactly SUMW cycles.
//   DONE: mean_out <= quotient[DW-1:0]; mean_valid=1 for this cycle only; return to IDLE.
//  Latency: start sampled at edge 0; mean_valid is high in cycle NK+SUMW+1 (defaults: 17+14+1=32).
//  Throughput: one window per NK+SUMW+2 cycles. Upstream must gate sort_finish with !busy.
//  Width: acc and dividend are SUMW bits and never overflow (NK*(2^DW-1)+NK/2 < 2^SUMW). The quotient is always
//   <= 2^DW-1, so truncating it to DW bits is lossless. The divisor is the constant NK; there is no divide-by-zero path.
//  Index out of range (seq[rank] >= DN): that pixel contributes 0; no error flag.
//  Start while busy: ignored. Latches, counters and the result are undisturbed, and no second result is queued.
//  Start in the DONE cycle: also ignored, because the FSM accepts only in IDLE.
//  Reset mid-operation: abort immediately, all outputs return to their reset values, and no mean_valid is issued.
//   The next start after reset is processed normally.
//  Inputs are not used after the capture edge; upstream may change them freely while busy.
// STRUCTURE
//  Package alpha_filt_pkg: DN, DW, TRIM, SW, NK, SUMW, FSM state encodings, and the rank-field / pixel-field slice helpers.
//  Sub-module seq_divider (SUMW-bit restoring divider):
//   ports clk, rst, load, dividend, divisor, quotient, done.
//   alpha_trim_mean holds the FSM, the latches, the rank mux and the accumulator, and instantiates one seq_divider.
// TESTING
//  1 Pixels i=0..24, identity sequence, TRIM=4 -> sum(4..20)=204, (204+8)/17 -> mean_out=12.
//    mean_valid is exactly 32 cycles after start; busy covers cycles 1..32.
//  2 All pixels 255 -> mean_out=255 (dividend 4343, quotient 255); no overflow.
//  3 Impulse noise: four pixels 0, four pixels 255, 17 pixels 100, with a correct sort sequence -> mean_out=100.
//  4 Rounding: trimmed tails 4x0 and 4x255 in all cases.
//    Kept 16x10+1x18 (sum 178) -> 10; kept 16x10+1x19 (sum 179) -> 11.
//  5 Second sort_finish 5 cycles after the first (while busy) -> ignored: one mean_valid, result of the first window only.
//    A start issued the cycle after mean_valid -> accepted, and its result arrives 32 cycles later.
//  6 Assert rst in cycle 10 (ACC) -> busy=0, mean_out=0, no mean_valid.
//    Then release rst and rerun test 1 -> mean_out=12 at +32 cycles.

Source files
------------

// File: rtl/alpha_filt_pkg.sv
// Shared widths, FSM encoding and field helpers for the alpha-trimmed mean stage.
package alpha_filt_pkg;

    localparam int unsigned DN        = 25;
    localparam int unsigned DW        = 8;
    localparam int unsigned TRIM      = 4;
    localparam int unsigned SW        = $clog2(DN);
    localparam int unsigned NK        = DN - 2 * TRIM;
    localparam int unsigned SUMW      = DW + $clog2(NK) + 1;
    localparam int unsigned LAST_RANK = DN - 1 - TRIM;

    // One-hot FSM encoding
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ACC  = 4'b0010,
        S_DIV  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    // Original pixel index stored at a given rank
    function automatic logic [SW-1:0] rank_field(input logic [SW*DN-1:0] seq,
                                                 input logic [SW-1:0]    rank);
        return seq[32'(rank) * SW +: SW];
    endfunction

    // Pixel at a given index; an out-of-range index reads as zero
    function automatic logic [DW-1:0] pixel_field(input logic [DW*DN-1:0] win,
                                                  input logic [SW-1:0]    idx);
        logic [DW-1:0] pix;
        pix = '0;
        if (32'(idx) < DN) begin
            pix = win[32'(idx) * DW +: DW];
        end
        return pix;
    endfunction

endpackage

// File: rtl/alpha_trim_mean_divider.sv
// Restoring divider, one quotient bit per clock, MSB first.
// The first step is folded into the load edge so the quotient is final
// W clocks after load, with done pulsing in the cycle it becomes valid.
module seq_divider
    import alpha_filt_pkg::*;
#(
    parameter int unsigned W = SUMW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    logic [W-1:0]  src_rem;
    logic [W-1:0]  src_quo;
    logic [W:0]    trial;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  step_quo;

    // One restoring step, taken from the fresh dividend on load
    always_comb begin
        src_rem  = load ? '0 : rem_q;
        src_quo  = load ? dividend : quo_q;
        trial    = {src_rem, src_quo[W-1]};
        step_rem = trial[W-1:0];
        step_quo = {src_quo[W-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            step_rem = W'(trial - {1'b0, divisor});
            step_quo = {src_quo[W-2:0], 1'b1};
        end
    end

    // Remainder / quotient shift registers and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem_q    <= step_rem;
                quo_q    <= step_quo;
                cnt_q    <= CW'(W - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean: latches a sorted 5x5 window, sums the middle-ranked
// pixels one per clock, then divides by the kept count with round-half-up.
module alpha_trim_mean
    import alpha_filt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sort_finish,
    input  logic [DW*DN-1:0] data_unsort,
    input  logic [SW*DN-1:0] sequence_sorted,
    output logic             busy,
    output logic [DW-1:0]    mean_out,
    output logic             mean_valid
);

    if (2 * TRIM >= DN) begin : g_trim_check
        $error("alpha_trim_mean: 2*TRIM must be smaller than DN");
    end

    state_t state_q;
    state_t state_nxt;

    logic [DW*DN-1:0] win_q;
    logic [SW*DN-1:0] seq_q;
    logic [SUMW-1:0]  acc_q;
    logic [SW-1:0]    rank_q;

    logic [DW-1:0]    cur_pix;
    logic [SUMW-1:0]  acc_sum;
    logic [SUMW-1:0]  dividend;
    logic             last_rank;

    logic             capture;
    logic             acc_en;
    logic             div_load;
    logic             busy_nxt;
    logic             done_nxt;

    logic [SUMW-1:0]  div_quot;
    logic             div_done;

    // Rank mux, running sum and rounded dividend
    always_comb begin
        cur_pix   = pixel_field(win_q, rank_field(seq_q, rank_q));
        acc_sum   = acc_q + SUMW'(cur_pix);
        dividend  = acc_sum + SUMW'(NK >> 1);
        last_rank = (rank_q == SW'(LAST_RANK));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (sort_finish) state_nxt = S_ACC;
            S_ACC:   if (last_rank)   state_nxt = S_DIV;
            S_DIV:   if (div_done)    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode; busy and valid are registered from the next state
    always_comb begin
        capture  = 1'b0;
        acc_en   = 1'b0;
        div_load = 1'b0;
        case (state_q)
            S_IDLE: capture = sort_finish;
            S_ACC: begin
                acc_en   = 1'b1;
                div_load = last_rank;
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // Window / sequence latches, accumulator and rank counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            seq_q  <= '0;
            acc_q  <= '0;
            rank_q <= '0;
        end else if (capture) begin
            win_q  <= data_unsort;
            seq_q  <= sequence_sorted;
            acc_q  <= '0;
            rank_q <= SW'(TRIM);
        end else if (acc_en) begin
            acc_q  <= acc_sum;
            rank_q <= rank_q + SW'(1);
        end
    end

    seq_divider #(
        .W (SUMW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (dividend),
        .divisor  (SUMW'(NK)),
        .quotient (div_quot),
        .done     (div_done)
    );

    // Registered outputs; upper quotient bits are always zero, saturate defensively
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            mean_valid <= 1'b0;
            mean_out   <= '0;
        end else begin
            busy       <= busy_nxt;
            mean_valid <= done_nxt;
            if (done_nxt) begin
                mean_out <= (|div_quot[SUMW-1:DW]) ? '1 : div_quot[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Self-checking bench for alpha_trim_mean: directed windows plus random traffic
// against a behavioural model of results, latency and busy window.
module tb_alpha_trim_mean;
    import alpha_filt_pkg::*;

    localparam int LAT = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sort_finish = 1'b0;
    logic [DW*DN-1:0] data_unsort = '0;
    logic [SW*DN-1:0] sequence_sorted = '0;
    logic             busy;
    logic [DW-1:0]    mean_out;
    logic             mean_valid;

    int errors = 0;
    int checks = 0;

    alpha_trim_mean dut (
        .clk             (clk),
        .rst             (rst),
        .sort_finish     (sort_finish),
        .data_unsort     (data_unsort),
        .sequence_sorted (sequence_sorted),
        .busy            (busy),
        .mean_out        (mean_out),
        .mean_valid      (mean_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Trimmed mean straight from the rules: drop TRIM ranks at each end, round half up
    function automatic int model_mean(input logic [DW*DN-1:0] d, input logic [SW*DN-1:0] q);
        int sum = 0;
        for (int r = int'(TRIM); r < int'(DN - TRIM); r++) begin
            int idx = int'(q[r*SW +: SW]);
            if (idx < int'(DN)) sum += int'(d[idx*DW +: DW]);
        end
        return (2 * sum + int'(NK)) / (2 * int'(NK));
    endfunction

    function automatic logic [DW*DN-1:0] pack_pix(input int p[DN]);
        logic [DW*DN-1:0] v = '0;
        for (int i = 0; i < int'(DN); i++) v[i*DW +: DW] = DW'(p[i]);
        return v;
    endfunction

    // Rank list built by a stable sort of pixel values
    function automatic logic [SW*DN-1:0] sort_seq(input int p[DN]);
        int s[DN];
        logic [SW*DN-1:0] v = '0;
        for (int i = 0; i < int'(DN); i++) s[i] = i;
        for (int i = 0; i < int'(DN) - 1; i++)
            for (int j = 0; j < int'(DN) - 1 - i; j++)
                if (p[s[j]] > p[s[j+1]]) begin
                    int t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        for (int r = 0; r < int'(DN); r++) v[r*SW +: SW] = SW'(s[r]);
        return v;
    endfunction

    // Reference model: tracks acceptance, busy window, valid pulse and held result
    int m_edge = -1;
    int m_s = 0;
    int m_pending = 0;
    int m_mean = 0;
    bit m_active = 1'b0;
    bit m_busy = 1'b0;
    bit m_valid = 1'b0;

    initial forever begin
        bit accept;
        @(posedge clk);
        m_edge++;
        if (rst) begin
            m_active = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_mean = 0;
        end else begin
            accept = sort_finish && (!m_active || m_edge > m_s + LAT);
            if (m_active && m_edge == m_s + LAT - 1) m_mean = m_pending;
            if (accept) begin
                m_active  = 1'b1;
                m_s       = m_edge;
                m_pending = model_mean(data_unsort, sequence_sorted);
            end
            m_busy  = m_active && m_edge >= m_s && m_edge < m_s + LAT;
            m_valid = m_active && m_edge == m_s + LAT - 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mean_valid", 32'(mean_valid), 32'(m_valid));
        chk("mean_out", 32'(mean_out), 32'(m_mean));
    end

    task automatic scramble();
        for (int i = 0; i < int'(DN); i++) begin
            data_unsort[i*DW +: DW]     = DW'($urandom);
            sequence_sorted[i*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic drive_start(input logic [DW*DN-1:0] d, input logic [SW*DN-1:0] q);
        @(negedge clk); #1;
        data_unsort = d; sequence_sorted = q; sort_finish = 1'b1;
        @(negedge clk); #1;
        sort_finish = 1'b0;
        scramble();
    endtask

    // Bounded wait for mean_valid; optionally fires one extra start at cycle inject_at
    task automatic wait_result(input int inject_at, input logic [DW*DN-1:0] d2,
                               input logic [SW*DN-1:0] q2, output int lat, output int bcnt);
        lat  = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcnt++;
            if (mean_valid === 1'b1) break;
            if (lat == inject_at) begin
                #1; data_unsort = d2; sequence_sorted = q2; sort_finish = 1'b1;
            end else if (sort_finish) begin
                #1; sort_finish = 1'b0;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mean_valid === 1'b1) n++;
        end
    endtask

    task automatic run_window(input string name, input int p[DN], input int exp_mean,
                              input int inject_at, input logic [DW*DN-1:0] d2,
                              input logic [SW*DN-1:0] q2);
        logic [DW*DN-1:0] d;
        logic [SW*DN-1:0] q;
        int lat, bcnt;
        d = pack_pix(p);
        q = sort_seq(p);
        chk({name, " model"}, 32'(model_mean(d, q)), 32'(exp_mean));
        drive_start(d, q);
        wait_result(inject_at, d2, q2, lat, bcnt);
        chk({name, " latency"}, 32'(lat), 32'(LAT));
        chk({name, " busy cycles"}, 32'(bcnt), 32'(LAT));
        chk({name, " mean"}, 32'(mean_out), 32'(exp_mean));
    endtask

    initial begin
        int ramp[DN], full[DN], imp[DN], r10[DN], r11[DN], rp[DN];
        logic [DW*DN-1:0] d_full;
        logic [SW*DN-1:0] q_full;
        int n;

        for (int i = 0; i < int'(DN); i++) begin
            ramp[i] = i;
            full[i] = 255;
            imp[i]  = (i % 6 == 1) ? 0 : ((i % 6 == 4) ? 255 : 100);
            r10[i]  = (i < 4) ? 0 : ((i < 8) ? 255 : 10);
            r11[i]  = r10[i];
        end
        r10[24] = 18;
        r11[24] = 19;
        d_full = pack_pix(full);
        q_full = sort_seq(full);

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset mean_out", 32'(mean_out), 32'(0));
        chk("reset mean_valid", 32'(mean_valid), 32'(0));
        #1 rst = 1'b0;

        run_window("ramp", ramp, 12, 0, '0, '0);
        run_window("all255", full, 255, 0, '0, '0);
        run_window("impulse", imp, 100, 0, '0, '0);
        run_window("round down", r10, 10, 0, '0, '0);
        run_window("round up", r11, 11, 0, '0, '0);

        // Start while busy is ignored; a start right after mean_valid is accepted
        run_window("busy start", ramp, 12, 5, d_full, q_full);
        run_window("back to back", full, 255, 0, '0, '0);
        count_valid(45, n);
        chk("no queued result", 32'(n), 32'(0));

        // Reset in the middle of accumulation
        drive_start(pack_pix(ramp), sort_seq(ramp));
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort mean_out", 32'(mean_out), 32'(0));
        chk("abort mean_valid", 32'(mean_valid), 32'(0));
        @(negedge clk); #1 rst = 1'b0;
        count_valid(45, n);
        chk("abort no result", 32'(n), 32'(0));
        run_window("after reset", ramp, 12, 0, '0, '0);

        // Random windows, extra starts, a few resets; the model checks every cycle
        for (int it = 0; it < 30; it++) begin
            logic [DW*DN-1:0] d;
            logic [SW*DN-1:0] q;
            int hi = (it % 3 == 0) ? 7 : 255;
            int gap = $urandom_range(20, 45);
            for (int i = 0; i < int'(DN); i++) rp[i] = $urandom_range(0, hi);
            d = pack_pix(rp);
            q = sort_seq(rp);
            if ($urandom_range(0, 3) == 0)
                q[$urandom_range(TRIM, LAST_RANK) * SW +: SW] = SW'($urandom_range(DN, 31));
            drive_start(d, q);
            for (int k = 0; k < gap; k++) begin
                @(negedge clk); #1;
                rst = (it % 10 == 7 && k == 5);
                sort_finish = ($urandom_range(0, 9) == 0);
                scramble();
            end
            @(negedge clk); #1;
            sort_finish = 1'b0;
            rst = 1'b0;
        end

        repeat (50) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
